// File: rtl/seq_detector_param_if.sv
// Serial detector bus: data bit with valid qualifier, runtime pattern config,
// counter clear, and the match pulse / match count returned by the detector.
interface seq_detector_param_if #(
  parameter int unsigned PAT_W = 6,
  parameter int unsigned CNT_W = 8
);
  localparam int unsigned LEN_W = $clog2(PAT_W + 1);

  logic             in;
  logic             in_valid;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic             cnt_clr;
  logic             out;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output in, in_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    input  out, match_cnt
  );

  modport slave (
    input  in, in_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    output out, match_cnt
  );
endinterface

// File: rtl/seq_detector_param.sv
// Programmable 1..PAT_W-bit serial pattern detector with overlap mode and a
// saturating match counter. Define SEQDET_REGOUT_EN to register the match pulse.
module seq_detector_param #(
  parameter int unsigned      PAT_W     = 6,
  parameter int unsigned      CNT_W     = 8,
  parameter logic [PAT_W-1:0] RESET_PAT = PAT_W'(6'b101011),
  parameter int unsigned      RESET_LEN = 6,
  parameter bit               RESET_OVL = 1'b0
) (
  input logic                 clk,
  input logic                 reset,
  seq_detector_param_if.slave bus
);

  localparam int unsigned      LEN_W   = $clog2(PAT_W + 1);
  localparam int unsigned      LW1     = LEN_W + 1;
  localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovl_q, ovl_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [LEN_W-1:0] eff_len_c;
  logic [PAT_W-1:0] win_c;
  logic [PAT_W-1:0] mask_c;
  logic             accept_c;
  logic             fill_ok_c;
  logic             match_c;

  // Mealy match: newest PAT_W bits (history plus current bit) against the low L pattern bits
  always_comb begin
    eff_len_c = (len_q > PAT_W_L) ? PAT_W_L : len_q;
    accept_c  = bus.in_valid & ~bus.cfg_load;
    win_c     = {hist_q[PAT_W-2:0], bus.in};
    mask_c    = '0;
    for (int unsigned i = 0; i < PAT_W; i++) begin
      mask_c[i] = (LEN_W'(i) < eff_len_c);
    end
    fill_ok_c = ({1'b0, fill_q} + LW1'(1)) >= {1'b0, eff_len_c};
    match_c   = accept_c && (eff_len_c != '0) && fill_ok_c &&
                (((win_c ^ pat_q) & mask_c) == '0);
  end

  always_comb begin
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    if (bus.cfg_load) begin
      pat_d  = bus.cfg_pattern;
      len_d  = bus.cfg_len;
      ovl_d  = bus.cfg_overlap;
      hist_d = '0;
      fill_d = '0;
    end else if (accept_c) begin
      hist_d = win_c;
      // Non-overlapping mode restarts the fill so the next match needs L fresh bits
      if (match_c && !ovl_q) begin
        fill_d = '0;
      end else if (fill_q < PAT_W_L) begin
        fill_d = fill_q + LEN_W'(1);
      end
    end
    if (bus.cnt_clr) begin
      cnt_d = '0;
    end else if (match_c && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q  <= RESET_PAT;
      len_q  <= LEN_W'(RESET_LEN);
      ovl_q  <= RESET_OVL;
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.match_cnt = cnt_q;

`ifdef SEQDET_REGOUT_EN
  logic out_q, out_d;

  // match_c is already low during cfg_load, so a load drops any pending pulse
  always_comb begin
    out_d = match_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= 1'b0;
    end else begin
      out_q <= out_d;
    end
  end

  assign bus.out = out_q;
`else
  assign bus.out = match_c;
`endif

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial bit-pattern detector, the next generation of the team's fixed-pattern Mealy sequence detector. Matches a runtime-programmable pattern of 1..PAT_W bits on a single-bit serial stream with a valid qualifier. Supports overlapping and non-overlapping match modes and keeps a saturating match counter. Sits on the serial receive path and feeds frame-sync and event-counting logic.

## Interface
- PAT_W, 6: maximum pattern length in bits (≥2).
- CNT_W, 8: match counter width.
- RESET_PAT, 6'b101011: pattern loaded at reset (PAT_W bits).
- RESET_LEN, 6: pattern length loaded at reset.
- RESET_OVL, 0: overlap mode loaded at reset.
- LEN_W, derived, $clog2(PAT_W+1): width of length fields.

- clk  input  1  single clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in  input  1  serial data bit.
- in_valid  input  1  qualifies `in`; bits with in_valid=0 are ignored.
- cfg_load  input  1  one-cycle strobe; captures cfg_pattern, cfg_len, cfg_overlap.
- cfg_pattern  input  PAT_W  pattern; bit [len-1] is the first bit received, bit [0] the last.
- cfg_len  input  LEN_W  pattern length.
- cfg_overlap  input  1  1 = overlapping matches, 0 = non-overlapping.
- cnt_clr  input  1  synchronous clear of match_cnt.
- out  output  1  match pulse.
- match_cnt  output  CNT_W  saturating count of matches.

## Operation
- State: config regs (pat, len, ovl), history shift register hist[PAT_W-1:0], fill counter fill[LEN_W-1:0], match_cnt.
- Effective length L = min(len, PAT_W); L=0 disables detection (out never asserts; history still shifts).
- Accepted bit: in_valid=1 and cfg_load=0. On an accepted bit: hist <= {hist[PAT_W-2:0], in}; fill <= min(fill+1, PAT_W).
- Match condition (Mealy, combinational): accepted bit, L≥1, fill+1 ≥ L, and {hist, in} low L bits == pat low L bits.
- On match: overlap=1 → history/fill updated normally; overlap=0 → fill <= 0 (next match requires L fresh bits; hist still shifts).
- match_cnt: +1 on each match edge, saturates at 2^CNT_W-1. cnt_clr=1 forces 0; cnt_clr wins over simultaneous match.
- cfg_load: captures config, clears hist and fill; the same-cycle `in` is discarded (no shift, no match). match_cnt unaffected.
- Reset (async, any time including mid-pattern): pat=RESET_PAT, len=RESET_LEN, ovl=RESET_OVL, hist=0, fill=0, match_cnt=0, out=0 (combinational out is 0 because fill=0 gates it until enough bits arrive).

## Timing
- out: zero-cycle latency, combinational from in/in_valid/cfg_load and registers (default build).
- match_cnt: updates on the edge where out=1; visible the following cycle.
- Config takes effect on the bit accepted in the cycle after cfg_load.
- No backpressure; one bit per cycle maximum.

## Configuration
- SEQDET_REGOUT_EN defined: out is registered, asserting one cycle after the matching bit's edge for exactly one cycle, reset value 0; cfg_load and reset clear the pending pulse. match_cnt timing unchanged.
- Undefined: out is the combinational Mealy pulse described above.

## Test plan
- Reset defaults, stream 1,0,1,0,1,1 (in_valid=1) → out=1 in the 6th cycle only; match_cnt=1 next cycle.
- cfg_load pattern 3'b101, len 3, overlap=1; stream 1,0,1,0,1 → out on bits 3 and 5, match_cnt=2. Repeat with overlap=0 → out on bit 3 only, match_cnt=1.
- Default pattern with in_valid=0 gaps of 1-3 cycles between bits → single match on 6th valid bit; no out in gap cycles.
- CNT_W=2, pattern 1'b1 len 1, five valid 1s → match_cnt saturates at 3; cnt_clr coincident with a match → match_cnt=0.
- Feed 1,0,1 then cfg_load (same pattern) with in=1,in_valid=1 → that bit discarded; subsequent 0,1,1 does not match; full 6 fresh bits match.
- Assert reset after 1,0,1,0,1 mid-stream, then send 1 → no match; match_cnt=0; config back to RESET_PAT/RESET_LEN.
